// File: rtl/seq_pkg.sv
// Shared types and constants for the serial pattern transmitter.
package seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int PAT_W_DEF = 4;
    localparam int CNT_W_DEF = 4;
    localparam int GAP_W_DEF = 3;

    localparam logic [PAT_W_DEF-1:0] DEF_PATTERN = 4'b1011;

endpackage

// File: rtl/seq_gen_shifter.sv
// PAT_W-bit MSB-first shift register with a bit counter that flags the last bit of a frame.
module seq_gen_shifter #(
    parameter int PAT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [PAT_W-1:0] load_val,
    output logic             msb,
    output logic             last_bit
);

    localparam int BW = (PAT_W > 2) ? $clog2(PAT_W) : 1;

    logic [PAT_W-1:0] sr;
    logic [BW-1:0]    bit_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            sr      <= load_val;
            bit_cnt <= '0;
        end else if (shift) begin
            sr      <= {sr[PAT_W-2:0], 1'b0};
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    assign msb      = sr[PAT_W-1];
    assign last_bit = (bit_cnt == BW'(PAT_W - 1));

endmodule

// File: rtl/seq_generator.sv
// Serial pattern transmitter: repeated MSB-first frames with optional idle gaps,
// driven by a start/busy/done handshake.
module seq_generator
    import seq_pkg::*;
#(
    parameter int               PAT_W       = PAT_W_DEF,
    parameter logic [PAT_W-1:0] DEF_PATTERN = seq_pkg::DEF_PATTERN,
    parameter int               CNT_W       = CNT_W_DEF,
    parameter int               GAP_W       = GAP_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             use_def,
    input  logic [PAT_W-1:0] pattern_in,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic [GAP_W-1:0] gap_len,
    output logic             x,
    output logic             valid,
    output logic             frame_first,
    output logic             busy,
    output logic             done
);

    state_t           state, state_n;
    logic [PAT_W-1:0] pat_q, load_val;
    logic [CNT_W-1:0] frames;
    logic [GAP_W-1:0] gap_q, gap_cnt;
    logic             load, shift, latch, frame_dec, gap_ld, gap_dec;
    logic             msb, last_bit, ff_q;

    seq_gen_shifter #(.PAT_W(PAT_W)) u_shifter (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .shift    (shift),
        .load_val (load_val),
        .msb      (msb),
        .last_bit (last_bit)
    );

    always_comb begin
        state_n   = state;
        load      = 1'b0;
        shift     = 1'b0;
        latch     = 1'b0;
        frame_dec = 1'b0;
        gap_ld    = 1'b0;
        gap_dec   = 1'b0;
        load_val  = pat_q;
        case (state)
            S_IDLE: if (start) begin
                latch    = 1'b1;
                load     = 1'b1;
                load_val = use_def ? DEF_PATTERN : pattern_in;
                state_n  = S_SEND;
            end
            S_SEND: if (!last_bit) begin
                shift = 1'b1;
            end else if (frames == '0) begin
                state_n = S_DONE;
            end else begin
                frame_dec = 1'b1;
                // zero gap reloads in place so the next MSB follows with no bubble
                if (gap_q != '0) begin
                    gap_ld  = 1'b1;
                    state_n = S_GAP;
                end else begin
                    load = 1'b1;
                end
            end
            S_GAP: if (gap_cnt == GAP_W'(1)) begin
                load    = 1'b1;
                state_n = S_SEND;
            end else begin
                gap_dec = 1'b1;
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            ff_q    <= 1'b0;
            pat_q   <= '0;
            frames  <= '0;
            gap_q   <= '0;
            gap_cnt <= '0;
        end else begin
            state <= state_n;
            ff_q  <= load;
            if (latch) begin
                pat_q  <= load_val;
                frames <= repeat_cnt;
                gap_q  <= gap_len;
            end
            if (frame_dec) frames <= frames - 1'b1;
            if (gap_ld)       gap_cnt <= gap_q;
            else if (gap_dec) gap_cnt <= gap_cnt - 1'b1;
        end
    end

    // Outputs decode registered state only; no input reaches them combinationally.
    assign valid       = (state == S_SEND);
    assign x           = valid & msb;
    assign frame_first = valid & ff_q;
    assign busy        = (state == S_SEND) || (state == S_GAP);
    assign done        = (state == S_DONE);

endmodule
